// File: rtl/uart_aes_pkg.sv
// Shared types, constants and helpers for the UART receive / AES block path.
package uart_aes_pkg;

    localparam int unsigned AES_BLOCK_BITS = 128;

    typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Clocks per oversample tick, floored; never below 1 so the divider always runs.
    function automatic int unsigned calc_tick_div(input int unsigned clk,
                                                  input int unsigned baud,
                                                  input int unsigned os);
        int unsigned d;
        d = clk / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial receive front-end: rx synchroniser, oversample tick divider and
// start/data/parity/stop state machine producing one byte strobe per good frame.
module uart_rx_core
    import uart_aes_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       sample_tick,
    output logic       rx_idle
);

    localparam int unsigned   TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned   TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    logic [31:0]   r_div_cnt;
    logic          r_tick;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    rx_state_t     r_state;
    logic [TW-1:0] r_tcnt;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_drop;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_frame_err;
    logic          r_parity_err;

    // Free-running divider producing a one-cycle oversample tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == 32'(TICK_DIV - 1)) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 32'd1;
            r_tick    <= 1'b0;
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Frame state machine; all bits sampled at their midpoint, outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tcnt       <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_drop       <= 1'b0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state <= START;
                        r_tcnt  <= '0;
                        r_drop  <= 1'b0;
                    end
                end
                START: begin
                    if (r_tick) begin
                        if (r_tcnt == HALF_M1) begin
                            r_tcnt <= '0;
                            if (r_rx_sync) begin
                                r_state <= IDLE;
                            end else begin
                                r_state  <= DATA;
                                r_bitcnt <= '0;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (r_tick) begin
                        if (r_tcnt == FULL_M1) begin
                            r_tcnt  <= '0;
                            r_shift <= {r_rx_sync, r_shift[7:1]};
                            if (r_bitcnt == 3'd7) begin
                                r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (r_tick) begin
                        if (r_tcnt == FULL_M1) begin
                            r_tcnt  <= '0;
                            r_state <= STOP;
                            if (r_rx_sync != ((^r_shift) ^ PAR_ODD)) begin
                                r_parity_err <= 1'b1;
                                r_drop       <= 1'b1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (r_tick) begin
                        if (r_tcnt == FULL_M1) begin
                            r_tcnt <= '0;
                            if (!r_rx_sync) begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end else begin
                                r_state <= IDLE;
                                if (!r_drop) begin
                                    r_byte       <= r_shift;
                                    r_byte_valid <= 1'b1;
                                end
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (r_rx_sync) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign byte_data   = r_byte;
    assign byte_valid  = r_byte_valid;
    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign sample_tick = r_tick;
    assign rx_idle     = (r_state == IDLE);

endmodule

// File: rtl/uart_rx_block_assembler.sv
// Packs received UART bytes into AES-sized blocks, presents them on a
// valid/ready stream, flushes partial blocks after an idle timeout and
// reports overrun when no buffer is free for a completed block.
module uart_rx_block_assembler
    import uart_aes_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned BLOCK_BYTES  = 16,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [AES_BLOCK_BITS-1:0] block_data,
    output logic [4:0]                block_nbytes,
    output logic                      block_valid,
    input  logic                      block_ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun
);

    localparam int unsigned   TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [4:0]    NB_FULL = 5'(BLOCK_BYTES);
    localparam logic [15:0]   TO_LIM  = 16'(TIMEOUT_BITS);

    logic [7:0]    w_byte;
    logic          w_byte_valid;
    logic          w_tick;
    logic          w_rx_idle;
    logic          w_full;
    logic          w_consume;
    logic          w_can_accept;
    logic          w_timeout;
    logic          w_flush_go;
    logic          w_push;
    logic [3:0]    w_wr_sel;

    aes_block_t    r_acc;
    logic [4:0]    r_count;
    logic          r_flush_pend;
    logic [TW-1:0] r_idle_sub;
    logic [15:0]   r_idle_bits;
    aes_block_t    r_out_data;
    logic [4:0]    r_out_nb;
    logic          r_out_valid;
    aes_block_t    r_hold_data;
    logic [4:0]    r_hold_nb;
    logic          r_hold_valid;
    logic          r_overrun;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (w_byte),
        .byte_valid  (w_byte_valid),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .sample_tick (w_tick),
        .rx_idle     (w_rx_idle)
    );

    assign w_full       = (r_count == NB_FULL);
    assign w_consume    = r_out_valid && block_ready;
    // A slot is free if the second buffer is empty or the presented block leaves this cycle.
    assign w_can_accept = !r_hold_valid || w_consume;
    assign w_timeout    = (TIMEOUT_BITS != 0) && (r_idle_bits == TO_LIM) && (r_count != '0);
    assign w_flush_go   = r_flush_pend && !w_full && !w_byte_valid && w_can_accept;
    assign w_push       = (w_full && w_can_accept) || w_flush_go;
    assign w_wr_sel     = 4'd15 - r_count[3:0];

    // Idle bit-time counter: runs only while the receiver idles with a partial block.
    always_ff @(posedge clk) begin
        if (reset || !w_rx_idle || (r_count == '0) || (TIMEOUT_BITS == 0)) begin
            r_idle_sub  <= '0;
            r_idle_bits <= '0;
        end else if (w_tick && (r_idle_bits != TO_LIM)) begin
            if (r_idle_sub == FULL_M1) begin
                r_idle_sub  <= '0;
                r_idle_bits <= r_idle_bits + 16'd1;
            end else begin
                r_idle_sub <= r_idle_sub + 1'b1;
            end
        end
    end

    // Byte accumulator, left-justified; cleared whenever its contents leave or are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_flush_pend <= 1'b0;
        end else if (w_full || w_flush_go) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_byte_valid) begin
                r_acc[{w_wr_sel, 3'b000} +: 8] <= w_byte;
                r_count                        <= r_count + 5'd1;
            end
            if (w_timeout) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Two-deep output: the presented block plus one waiting block behind it;
    // the waiting block always moves forward before a new one is placed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_nb     <= '0;
            r_out_valid  <= 1'b0;
            r_hold_data  <= '0;
            r_hold_nb    <= '0;
            r_hold_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_full && !w_can_accept;
            if (!r_out_valid || w_consume) begin
                if (r_hold_valid) begin
                    r_out_data   <= r_hold_data;
                    r_out_nb     <= r_hold_nb;
                    r_out_valid  <= 1'b1;
                    r_hold_valid <= w_push;
                    if (w_push) begin
                        r_hold_data <= r_acc;
                        r_hold_nb   <= r_count;
                    end
                end else if (w_push) begin
                    r_out_data  <= r_acc;
                    r_out_nb    <= r_count;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_hold_data  <= r_acc;
                r_hold_nb    <= r_count;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign block_data   = r_out_data;
    assign block_nbytes = r_out_nb;
    assign block_valid  = r_out_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_uart_rx_block_assembler.sv
// Bench for uart_rx_block_assembler: instance A (no parity) and instance B (even parity).
module tb_uart_rx_block_assembler;

    localparam int unsigned CLK_HZ   = 3_200_000;
    localparam int unsigned BAUD_HZ  = 100_000;
    localparam int unsigned OS       = 16;
    localparam int          BIT_CLKS = 32;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   nb;
    } blk_t;

    typedef struct {
        logic [7:0] data;
        int         par;
        int         stop_low;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         rx_a  = 1'b1;
    logic         rx_b  = 1'b1;
    logic         rdy_a = 1'b1;
    logic         rdy_b = 1'b1;
    logic [127:0] bd [2];
    logic [4:0]   nb [2];
    logic         bv [2];
    logic         fe [2];
    logic         pe [2];
    logic         ov [2];

    int   n_assert = 0;
    int   n_fail   = 0;
    int   nfe [2]  = '{0, 0};
    int   npe [2]  = '{0, 0};
    int   nov [2]  = '{0, 0};
    blk_t q_a [$];
    blk_t q_b [$];
    blk_t exp_a;
    blk_t exp_b;

    always #5 clk = ~clk;

    uart_rx_block_assembler #(
        .CLK_FREQ(CLK_HZ), .BAUD(BAUD_HZ), .OVERSAMPLE(OS), .PARITY_EN(0),
        .PARITY_ODD(0), .BLOCK_BYTES(16), .TIMEOUT_BITS(40)
    ) u_dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .block_data(bd[0]), .block_nbytes(nb[0]),
        .block_valid(bv[0]), .block_ready(rdy_a), .frame_err(fe[0]), .parity_err(pe[0]),
        .overrun(ov[0])
    );

    uart_rx_block_assembler #(
        .CLK_FREQ(CLK_HZ), .BAUD(BAUD_HZ), .OVERSAMPLE(OS), .PARITY_EN(1),
        .PARITY_ODD(0), .BLOCK_BYTES(16), .TIMEOUT_BITS(40)
    ) u_dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .block_data(bd[1]), .block_nbytes(nb[1]),
        .block_valid(bv[1]), .block_ready(rdy_b), .frame_err(fe[1]), .parity_err(pe[1]),
        .overrun(ov[1])
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic blk_t mk_blk(input logic [7:0] first, input int n);
        blk_t b;
        b.data = '0;
        for (int i = 0; i < n; i++) b.data = (b.data << 8) | 128'(first + 8'(i));
        b.data = b.data << (8 * (16 - n));
        b.nb   = 5'(n);
        return b;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (fe[d]) nfe[d]++;
                if (pe[d]) npe[d]++;
                if (ov[d]) nov[d]++;
            end
            if (bv[0] && rdy_a) begin
                if (q_a.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL A unexpected block: got %0h, expected none", bd[0]);
                end else begin
                    exp_a = q_a.pop_front();
                    chk("A block data", bd[0], exp_a.data);
                    chk("A block nbytes", 128'(nb[0]), 128'(exp_a.nb));
                end
            end else if (bv[0] && q_a.size() != 0) begin
                chk("A held block data", bd[0], q_a[0].data);
                chk("A held block nbytes", 128'(nb[0]), 128'(q_a[0].nb));
            end
            if (bv[1] && rdy_b) begin
                if (q_b.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL B unexpected block: got %0h, expected none", bd[1]);
                end else begin
                    exp_b = q_b.pop_front();
                    chk("B block data", bd[1], exp_b.data);
                    chk("B block nbytes", 128'(nb[1]), 128'(exp_b.nb));
                end
            end
        end
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic bits(input int n);
        repeat (n * BIT_CLKS) @(posedge clk);
        #2;
    endtask

    // par: 0 = no parity bit, 1 = correct even parity, 2 = inverted parity.
    task automatic send(input int d, input logic [7:0] b, input int par, input int stop_low);
        logic p;
        set_rx(d, 1'b0); bits(1);
        for (int i = 0; i < 8; i++) begin
            set_rx(d, b[i]); bits(1);
        end
        if (par != 0) begin
            p = ^b;
            if (par == 2) p = ~p;
            set_rx(d, p); bits(1);
        end
        if (stop_low > 0) begin
            set_rx(d, 1'b0); bits(stop_low);
        end
        set_rx(d, 1'b1); bits(1);
    endtask

    task automatic drain(input int d, input int max_cyc);
        int c = 0;
        while (((d == 0) ? q_a.size() : q_b.size()) != 0 && c < max_cyc) begin
            @(posedge clk);
            c++;
        end
        #2;
        chk((d == 0) ? "A drain" : "B drain", 128'((d == 0) ? q_a.size() : q_b.size()), 128'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t tv [20];
        int   pb, fb;

        tv[0] = '{8'h07, 2, 0, 1, 0};
        tv[1] = '{8'h81, 2, 0, 1, 0};
        tv[2] = '{8'hC3, 1, 2, 0, 1};
        tv[3] = '{8'hE7, 2, 1, 1, 1};
        for (int i = 0; i < 16; i++) tv[4 + i] = '{8'(8'h30 + i), 1, 0, 0, 0};

        reset = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        for (int d = 0; d < 2; d++) begin
            chk("reset block_data", bd[d], 128'd0);
            chk("reset block_nbytes", 128'(nb[d]), 128'd0);
            chk("reset block_valid", 128'(bv[d]), 128'd0);
            chk("reset error pulses", 128'({fe[d], pe[d], ov[d]}), 128'd0);
        end

        // Full block of 0x00..0x0F.
        q_a.push_back('{128'h000102030405060708090A0B0C0D0E0F, 5'd16});
        for (int i = 0; i < 16; i++) send(0, 8'(i), 0, 0);
        drain(0, 4 * BIT_CLKS);
        chk("A errors after full block", 128'(nfe[0] + npe[0] + nov[0]), 128'd0);

        // Partial block flushed by idle timeout.
        q_a.push_back('{{40'hA1A2A3A4A5, 88'h0}, 5'd5});
        for (int i = 0; i < 5; i++) send(0, 8'(8'hA1 + i), 0, 0);
        bits(38);
        chk("A no early flush", 128'(q_a.size()), 128'd1);
        drain(0, 4 * BIT_CLKS);

        // Stop bit held low: byte dropped, next byte received.
        fb = nfe[0];
        send(0, 8'h55, 0, 2);
        chk("A frame_err pulse", 128'(nfe[0] - fb), 128'd1);
        q_a.push_back(mk_blk(8'h3C, 1));
        send(0, 8'h3C, 0, 0);
        drain(0, 45 * BIT_CLKS);

        // Back-pressure: two blocks buffered, third dropped with overrun.
        rdy_a = 1'b0;
        q_a.push_back(mk_blk(8'h40, 16));
        q_a.push_back(mk_blk(8'h50, 16));
        for (int i = 0; i < 47; i++) send(0, 8'(8'h40 + i), 0, 0);
        chk("A no overrun before byte 48", 128'(nov[0]), 128'd0);
        chk("A block held valid", 128'(bv[0]), 128'd1);
        send(0, 8'h6F, 0, 0);
        chk("A overrun pulse", 128'(nov[0]), 128'd1);
        rdy_a = 1'b1;
        drain(0, 20);
        bits(2);

        // Even parity table on instance B.
        q_b.push_back(mk_blk(8'h30, 16));
        for (int i = 0; i < 20; i++) begin
            pb = npe[1];
            fb = nfe[1];
            send(1, tv[i].data, tv[i].par, tv[i].stop_low);
            chk($sformatf("B vec %0d parity_err", i), 128'(npe[1] - pb), 128'(tv[i].exp_perr));
            chk($sformatf("B vec %0d frame_err", i), 128'(nfe[1] - fb), 128'(tv[i].exp_ferr));
        end
        drain(1, 4 * BIT_CLKS);
        chk("B overrun count", 128'(nov[1]), 128'd0);

        // Reset after 7 bytes and mid-frame: nothing stale may appear.
        for (int i = 0; i < 7; i++) send(0, 8'(8'h90 + i), 0, 0);
        set_rx(0, 1'b0);
        bits(3);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        set_rx(0, 1'b1);
        bits(2);
        chk("A valid after reset", 128'(bv[0]), 128'd0);
        chk("A data after reset", bd[0], 128'd0);
        q_a.push_back(mk_blk(8'hF0, 16));
        for (int i = 0; i < 16; i++) send(0, 8'(8'hF0 + i), 0, 0);
        drain(0, 4 * BIT_CLKS);
        bits(45);
        chk("A final frame_err count", 128'(nfe[0]), 128'd1);
        chk("A final parity_err count", 128'(npe[0]), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
